// File: rtl/risc_pkg.sv
// Shared ISA constants, field positions and sequencer state type for the
// LM/SM expansion stage.
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_W    = 4;
  localparam int REG_W   = 3;
  localparam int OFF_W   = 6;
  localparam int BMAP_W  = 8;

  localparam logic [OP_W-1:0] OP_LW = 4'b0100;
  localparam logic [OP_W-1:0] OP_SW = 4'b0101;
  localparam logic [OP_W-1:0] OP_LM = 4'b0110;
  localparam logic [OP_W-1:0] OP_SM = 4'b0111;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int BMAP_MSB = 7;
  localparam int BMAP_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } seq_state_e;

  function automatic logic [INSTR_W-1:0] make_uop(
    input logic [OP_W-1:0]  op,
    input logic [REG_W-1:0] ri,
    input logic [REG_W-1:0] ra,
    input logic [OFF_W-1:0] off
  );
    return {op, ri, ra, off};
  endfunction

endpackage

// File: rtl/lm_sm_pick.sv
// Chooses the next register of an LM/SM sequence, its address offset and
// whether it is the final micro-op.
module lm_sm_pick
  import risc_pkg::*;
(
  input  logic [BMAP_W-1:0] rem_mask,
  input  logic [BMAP_W-1:0] bitmap,
  input  logic [REG_W-1:0]  ra,
  input  logic              is_lm,
  output logic [REG_W-1:0]  sel_idx,
  output logic [OFF_W-1:0]  sel_off,
  output logic              sel_last
);

  logic [BMAP_W-1:0] ra_bit;
  logic [BMAP_W-1:0] cand;
  logic [BMAP_W-1:0] below;
  logic [3:0]        rem_cnt;

  always_comb begin
    ra_bit = 8'b1 << ra;
    // A load of the base register waits until every other register is done.
    cand = rem_mask;
    if (is_lm && ((rem_mask & ~ra_bit) != '0))
      cand = rem_mask & ~ra_bit;

    sel_idx = '0;
    for (int i = BMAP_W - 1; i >= 0; i--)
      if (cand[i]) sel_idx = 3'(i);

    below   = bitmap & ((8'b1 << sel_idx) - 8'd1);
    sel_off = '0;
    for (int i = 0; i < BMAP_W; i++)
      sel_off = sel_off + 6'(below[i]);

    rem_cnt = '0;
    for (int i = 0; i < BMAP_W; i++)
      rem_cnt = rem_cnt + 4'(rem_mask[i]);
    sel_last = (rem_cnt == 4'd1);
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// IF/ID register that expands LM/SM into single-register LW/SW micro-ops,
// holding fetch while a multi-register sequence is in progress.
module lm_sm_sequencer
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] pc_in,
  input  logic               instr_valid,
  input  logic               stall_in,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] pc_out,
  output logic               valid_out,
  output logic               uop_last,
  output logic               stall_fetch
);

  seq_state_e        state_p1, state_nx;
  logic [OP_W-1:0]   uop_op_p1, uop_op_nx;
  logic              is_lm_p1, is_lm_nx;
  logic [REG_W-1:0]  ra_p1, ra_nx;
  logic [BMAP_W-1:0] bmap_p1, bmap_nx;
  logic [BMAP_W-1:0] rem_p1, rem_nx;
  logic [INSTR_W-1:0] instr_nx, pc_nx;
  logic              vld_nx, last_nx;

  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_ra;
  logic [BMAP_W-1:0] in_bmap;
  logic              in_is_lm, in_is_multi;
  logic              in_seq;

  logic [BMAP_W-1:0] pk_rem, pk_bmap;
  logic [REG_W-1:0]  pk_ra;
  logic              pk_lm;
  logic [OP_W-1:0]   pk_op;
  logic [REG_W-1:0]  sel_idx;
  logic [OFF_W-1:0]  sel_off;
  logic              sel_last;

  assign in_op       = instr_in[OP_MSB:OP_LSB];
  assign in_ra       = instr_in[RA_MSB:RA_LSB];
  assign in_bmap     = instr_in[BMAP_MSB:BMAP_LSB];
  assign in_is_lm    = (in_op == OP_LM);
  assign in_is_multi = in_is_lm || (in_op == OP_SM);
  assign in_seq      = (state_p1 == SEQ);

  // In IDLE the picker works straight off the incoming instruction.
  assign pk_rem  = in_seq ? rem_p1    : in_bmap;
  assign pk_bmap = in_seq ? bmap_p1   : in_bmap;
  assign pk_ra   = in_seq ? ra_p1     : in_ra;
  assign pk_lm   = in_seq ? is_lm_p1  : in_is_lm;
  assign pk_op   = in_seq ? uop_op_p1 : (in_is_lm ? OP_LW : OP_SW);

  lm_sm_pick u_pick (
    .rem_mask (pk_rem),
    .bitmap   (pk_bmap),
    .ra       (pk_ra),
    .is_lm    (pk_lm),
    .sel_idx  (sel_idx),
    .sel_off  (sel_off),
    .sel_last (sel_last)
  );

  assign stall_fetch = stall_in | in_seq;

  always_comb begin
    state_nx  = state_p1;
    uop_op_nx = uop_op_p1;
    is_lm_nx  = is_lm_p1;
    ra_nx     = ra_p1;
    bmap_nx   = bmap_p1;
    rem_nx    = rem_p1;
    instr_nx  = instr_out;
    pc_nx     = pc_out;
    vld_nx    = valid_out;
    last_nx   = uop_last;

    if (flush) begin
      vld_nx   = 1'b0;
      last_nx  = 1'b0;
      state_nx = IDLE;
      rem_nx   = '0;
      bmap_nx  = '0;
    end else if (!stall_in) begin
      case (state_p1)
        IDLE: begin
          if (!instr_valid) begin
            vld_nx  = 1'b0;
            last_nx = 1'b0;
          end else if (!in_is_multi) begin
            instr_nx = instr_in;
            pc_nx    = pc_in;
            vld_nx   = 1'b1;
            last_nx  = 1'b1;
          end else if (in_bmap == '0) begin
            vld_nx  = 1'b0;
            last_nx = 1'b0;
          end else begin
            instr_nx = make_uop(pk_op, sel_idx, in_ra, sel_off);
            pc_nx    = pc_in;
            vld_nx   = 1'b1;
            last_nx  = sel_last;
            if (!sel_last) begin
              state_nx  = SEQ;
              uop_op_nx = pk_op;
              is_lm_nx  = in_is_lm;
              ra_nx     = in_ra;
              bmap_nx   = in_bmap;
              rem_nx    = in_bmap & ~(8'b1 << sel_idx);
            end
          end
        end
        SEQ: begin
          instr_nx = make_uop(uop_op_p1, sel_idx, ra_p1, sel_off);
          vld_nx   = 1'b1;
          last_nx  = sel_last;
          rem_nx   = rem_p1 & ~(8'b1 << sel_idx);
          if (sel_last) begin
            state_nx = IDLE;
            bmap_nx  = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= IDLE;
      uop_op_p1 <= '0;
      is_lm_p1  <= 1'b0;
      ra_p1     <= '0;
      bmap_p1   <= '0;
      rem_p1    <= '0;
      instr_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
      uop_last  <= 1'b0;
    end else begin
      state_p1  <= state_nx;
      uop_op_p1 <= uop_op_nx;
      is_lm_p1  <= is_lm_nx;
      ra_p1     <= ra_nx;
      bmap_p1   <= bmap_nx;
      rem_p1    <= rem_nx;
      instr_out <= instr_nx;
      pc_out    <= pc_nx;
      valid_out <= vld_nx;
      uop_last  <= last_nx;
    end
  end

endmodule
